// File: rtl/vec_sequencer.sv
// Stimulus sequencer for the NOT/AND/OR/XOR + DFF test datapath: walks a
// deterministic vector set onto a/b/c/d, holds each for SETTLE edges, samples
// out1/out2 against a golden model and counts mismatching vectors.
// Ports: clk/rst (async active-high); start -> busy/done run handshake;
// a/b/c/d drive the datapath; out1/out2 are its outputs under test;
// vec_idx is the current/last vector; err_count saturates at 255.
// Optional feature macro: VEC_SEQ_STOP_ON_ERR_EN (stop the run at the first mismatch).
module vec_sequencer #(
    parameter int NUM_VECS = 16,
    parameter int SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [7:0] d,
    input  logic       out1,
    input  logic       out2,
    output logic [7:0] vec_idx,
    output logic [7:0] err_count
);
    // Hold counter only needs to reach SETTLE-1.
    localparam int              HW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [HW-1:0]   HOLD_INIT = HW'(SETTLE - 1);
    localparam logic [7:0]      LAST_IDX  = 8'(NUM_VECS - 1);
`ifdef VEC_SEQ_STOP_ON_ERR_EN
    localparam bit              STOP_ON_ERR = 1'b1;
`else
    localparam bit              STOP_ON_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q;
    logic [HW-1:0] hold_q;
    logic          busy_q;
    logic          done_q;
    logic          a_q;
    logic          b_q;
    logic          c_q;
    logic [7:0]    d_q;
    logic [7:0]    vec_idx_q;
    logic [7:0]    err_count_q;

    // Vector i packed as {a, b, c, d}.
    function automatic logic [10:0] vec_of(input logic [7:0] i);
        return {i[0], i[1], i[2], (i[3] ? 8'hFF : {4'h0, i[7:4]})};
    endfunction

    logic        gold_dff;
    logic        gold_exp1;
    logic        gold_exp2;
    logic        mismatch;
    logic [7:0]  idx_next_d;
    logic [10:0] vec_next_d;

    // Golden model evaluated on the vector currently held on the outputs.
    always_comb begin
        gold_dff   = (a_q & b_q) ^ (b_q | c_q);
        gold_exp1  = ~a_q & gold_dff;
        gold_exp2  = gold_dff ^ (&d_q);
        mismatch   = (out1 != gold_exp1) || (out2 != gold_exp2);
        idx_next_d = vec_idx_q + 8'd1;
        vec_next_d = vec_of(idx_next_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            c_q         <= 1'b0;
            d_q         <= 8'h00;
            vec_idx_q   <= 8'h00;
            err_count_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q               <= APPLY;
                        busy_q                <= 1'b1;
                        vec_idx_q             <= 8'h00;
                        err_count_q           <= 8'h00;
                        hold_q                <= HOLD_INIT;
                        {a_q, b_q, c_q, d_q}  <= vec_of(8'h00);
                    end
                end
                APPLY: begin
                    if (hold_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                SAMPLE: begin
                    // A vector counts once even if both outputs are wrong.
                    if (mismatch && (err_count_q != 8'hFF)) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                    if ((STOP_ON_ERR && mismatch) || (vec_idx_q == LAST_IDX)) begin
                        // vec_idx keeps the last (or failing) index.
                        state_q              <= DONE;
                        busy_q               <= 1'b0;
                        done_q               <= 1'b1;
                        {a_q, b_q, c_q, d_q} <= 11'd0;
                    end else begin
                        state_q              <= APPLY;
                        vec_idx_q            <= idx_next_d;
                        hold_q               <= HOLD_INIT;
                        {a_q, b_q, c_q, d_q} <= vec_next_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign d         = d_q;
    assign vec_idx   = vec_idx_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_vec_sequencer.sv
// Bench for vec_sequencer: a default instance (16 vectors, SETTLE=2) and a
// 256-vector SETTLE=1 instance, each driving a behavioural copy of the
// NOT/AND/OR/XOR+DFF datapath with selectable output faults.
module tb_vec_sequencer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // fault: 0 = healthy, 1 = out2 stuck at 0, 2 = out1 stuck at 0, 3 = both inverted
    int   fault;
    logic sel;              // 0 = default instance, 1 = big instance

    logic       s_start, s_busy, s_done, s_a, s_b, s_c, s_out1, s_out2;
    logic [7:0] s_d, s_vec_idx, s_err_count;
    logic       g_start, g_busy, g_done, g_a, g_b, g_c, g_out1, g_out2;
    logic [7:0] g_d, g_vec_idx, g_err_count;

    vec_sequencer u_dut (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .a(s_a), .b(s_b), .c(s_c), .d(s_d), .out1(s_out1), .out2(s_out2),
        .vec_idx(s_vec_idx), .err_count(s_err_count)
    );

    vec_sequencer #(.NUM_VECS(256), .SETTLE(1)) u_big (
        .clk(clk), .rst(rst), .start(g_start), .busy(g_busy), .done(g_done),
        .a(g_a), .b(g_b), .c(g_c), .d(g_d), .out1(g_out1), .out2(g_out2),
        .vec_idx(g_vec_idx), .err_count(g_err_count)
    );

    // Datapath under test, one copy per sequencer.
    logic s_dff_q, g_dff_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_dff_q <= 1'b0;
            g_dff_q <= 1'b0;
        end else begin
            s_dff_q <= (s_a & s_b) ^ (s_b | s_c);
            g_dff_q <= (g_a & g_b) ^ (g_b | g_c);
        end
    end

    logic s_raw1, s_raw2, g_raw1, g_raw2;
    assign s_raw1 = ~s_a & s_dff_q;
    assign s_raw2 = s_dff_q ^ (&s_d);
    assign g_raw1 = ~g_a & g_dff_q;
    assign g_raw2 = g_dff_q ^ (&g_d);

    assign s_out1 = (fault == 2) ? 1'b0 : (fault == 3) ? ~s_raw1 : s_raw1;
    assign s_out2 = (fault == 1) ? 1'b0 : (fault == 3) ? ~s_raw2 : s_raw2;
    assign g_out1 = (fault == 2) ? 1'b0 : (fault == 3) ? ~g_raw1 : g_raw1;
    assign g_out2 = (fault == 1) ? 1'b0 : (fault == 3) ? ~g_raw2 : g_raw2;

    // Selected instance's observables.
    logic        m_busy, m_done;
    logic [10:0] m_abcd;
    logic [7:0]  m_vec_idx, m_err_count;
    assign m_busy      = sel ? g_busy : s_busy;
    assign m_done      = sel ? g_done : s_done;
    assign m_abcd      = sel ? {g_a, g_b, g_c, g_d} : {s_a, s_b, s_c, s_d};
    assign m_vec_idx   = sel ? g_vec_idx : s_vec_idx;
    assign m_err_count = sel ? g_err_count : s_err_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start on the selected instance and watch the run from cycle 1
    // (first negedge after the sampling edge). Bounded to 2000 cycles.
    task automatic run(input int cyc_a, input int cyc_b,
                       output int nbusy, output int done_cyc, output int ndone,
                       output logic [10:0] cap_a, output logic [10:0] cap_b);
        int cycle;
        nbusy    = 0;
        done_cyc = 0;
        ndone    = 0;
        cap_a    = '0;
        cap_b    = '0;
        @(negedge clk);
        if (sel) g_start = 1'b1; else s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        g_start = 1'b0;
        cycle   = 1;
        while (cycle <= 2000) begin
            if (m_busy) nbusy++;
            if (m_done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cycle;
            end
            if (cycle == cyc_a) cap_a = m_abcd;
            if (cycle == cyc_b) cap_b = m_abcd;
            if (done_cyc != 0 && cycle >= done_cyc + 2) break;
            @(negedge clk);
            cycle++;
        end
    endtask

    int          nb, dc, nd;
    logic [10:0] ca, cb;

`ifdef VEC_SEQ_STOP_ON_ERR_EN
    localparam int F_BUSY = 9,  F_DONE = 10, F2_ERR = 1, F2_IDX = 2, F1_ERR = 1, F1_IDX = 2;
    localparam int G_BUSY = 2,  G_DONE = 3,  G_ERR  = 1, G_IDX  = 0;
`else
    localparam int F_BUSY = 48, F_DONE = 49, F2_ERR = 8, F2_IDX = 15, F1_ERR = 6, F1_IDX = 15;
    localparam int G_BUSY = 512, G_DONE = 513, G_ERR = 255, G_IDX = 255;
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        fault   = 0;
        sel     = 1'b0;
        s_start = 1'b0;
        g_start = 1'b0;
        rst     = 1'b0;
        #2 rst  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  {31'd0, s_busy}, 32'd0);
        check_eq("rst_done",  {31'd0, s_done}, 32'd0);
        check_eq("rst_abcd",  {21'd0, s_a, s_b, s_c, s_d}, 32'd0);
        check_eq("rst_idx",   {24'd0, s_vec_idx}, 32'd0);
        check_eq("rst_err",   {24'd0, s_err_count}, 32'd0);
        rst = 1'b0;

        // Healthy datapath: vector 5 at cycle 16, vector 9 at cycle 28.
        run(16, 28, nb, dc, nd, ca, cb);
        check_eq("ok_busy_cycles", nb, 48);
        check_eq("ok_done_cycle",  dc, 49);
        check_eq("ok_done_width",  nd, 1);
        check_eq("ok_vec5",        {21'd0, ca}, 32'h500);
        check_eq("ok_vec9",        {21'd0, cb}, 32'h4FF);
        check_eq("ok_err",         {24'd0, s_err_count}, 32'd0);
        check_eq("ok_idx",         {24'd0, s_vec_idx}, 32'd15);
        check_eq("ok_idle_busy",   {31'd0, s_busy}, 32'd0);

        // out2 stuck at 0: vectors 2,4,5,6,8,9,11,15 fail.
        fault = 1;
        run(0, 0, nb, dc, nd, ca, cb);
        check_eq("o2_busy_cycles", nb, F_BUSY);
        check_eq("o2_done_cycle",  dc, F_DONE);
        check_eq("o2_err",         {24'd0, s_err_count}, F2_ERR);
        check_eq("o2_idx",         {24'd0, s_vec_idx}, F2_IDX);

        // out1 stuck at 0: vectors 2,4,6,10,12,14 fail.
        fault = 2;
        run(0, 0, nb, dc, nd, ca, cb);
        check_eq("o1_err", {24'd0, s_err_count}, F1_ERR);
        check_eq("o1_idx", {24'd0, s_vec_idx}, F1_IDX);

        // Start while busy is ignored; reset mid-run clears everything at once.
        fault = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;                           // cycle 1
        repeat (9) @(negedge clk);                // cycle 10
        s_start = 1'b1;
        @(negedge clk);                           // cycle 11
        s_start = 1'b0;
        check_eq("busy_start_idx",  {24'd0, s_vec_idx}, 32'd3);
        check_eq("busy_start_busy", {31'd0, s_busy}, 32'd1);
        repeat (8) @(negedge clk);                // cycle 19
        check_eq("pre_rst_idx", {24'd0, s_vec_idx}, 32'd6);
        @(negedge clk);                           // cycle 20
        check_eq("pre_rst_busy", {31'd0, s_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", {31'd0, s_busy}, 32'd0);
        check_eq("mid_rst_abcd", {21'd0, s_a, s_b, s_c, s_d}, 32'd0);
        check_eq("mid_rst_idx",  {24'd0, s_vec_idx}, 32'd0);
        check_eq("mid_rst_err",  {24'd0, s_err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 0, nb, dc, nd, ca, cb);
        check_eq("post_rst_busy_cycles", nb, 48);
        check_eq("post_rst_done_cycle",  dc, 49);
        check_eq("post_rst_err",         {24'd0, s_err_count}, 32'd0);

        // 256 vectors, SETTLE=1, both outputs inverted: err_count saturates.
        sel   = 1'b1;
        fault = 3;
        run(107, 1, nb, dc, nd, ca, cb);
        check_eq("big_busy_cycles", nb, G_BUSY);
        check_eq("big_done_cycle",  dc, G_DONE);
        check_eq("big_err",         {24'd0, g_err_count}, G_ERR);
        check_eq("big_idx",         {24'd0, g_vec_idx}, G_IDX);
        check_eq("big_vec0",        {21'd0, cb}, 32'h000);
`ifndef VEC_SEQ_STOP_ON_ERR_EN
        check_eq("big_vec53",       {21'd0, ca}, 32'h503);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
